// File: rtl/keypoint_buffer.sv
// keypoint_buffer: per-frame keypoint FIFO between the FAST detector and its
// consumer. Collects keypoints between frame start/end pulses, caps them at
// MAX_KP, counts overflow drops and signals when the frame has fully drained.
// Head entry is first-word-fall-through.
// Optional build macro KP_SCORE_FILTER_EN adds i_score_th; keypoints scoring
// below it are discarded without being counted.
module keypoint_buffer #(
  parameter int DEPTH  = 64,
  parameter int MAX_KP = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_end,
  input  logic        i_flag,
  input  logic [9:0]  i_coordinate_X,
  input  logic [9:0]  i_coordinate_Y,
  input  logic [7:0]  i_score,
  input  logic [11:0] i_cos,
  input  logic [11:0] i_sin,
`ifdef KP_SCORE_FILTER_EN
  input  logic [7:0]  i_score_th,
`endif
  input  logic        i_ready,
  output logic        o_valid,
  output logic [9:0]  o_coordinate_X,
  output logic [9:0]  o_coordinate_Y,
  output logic [7:0]  o_score,
  output logic [11:0] o_cos,
  output logic [11:0] o_sin,
  output logic [9:0]  o_count,
  output logic [15:0] o_drop,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        done_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [51:0] mem [DEPTH];
  logic [51:0] head;
  logic        empty, full, kp_ok, below_cap, wr_en, drop_en, pop;
  logic [AW-1:0] wr_idx;

  // Pointers carry a wrap bit: equal -> empty, equal index with differing wrap -> full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef KP_SCORE_FILTER_EN
  assign kp_ok = i_flag && (i_score >= i_score_th);
`else
  assign kp_ok = i_flag;
`endif

  // A start flushes first, so a coincident keypoint always lands in slot 0.
  assign below_cap = (o_count < 10'(MAX_KP));
  assign wr_en   = kp_ok && (i_start || (state == COLLECT && !full && below_cap));
  assign drop_en = kp_ok && !i_start && (state == COLLECT) && (full || !below_cap);
  assign wr_idx  = i_start ? '0 : wr_ptr[AW-1:0];

  assign o_valid = (state != IDLE) && !empty;
  assign pop     = o_valid && i_ready;
  assign o_busy  = (state != IDLE);

  // Head fields read straight from memory; forced to zero while idle.
  assign head = (state == IDLE) ? 52'd0 : mem[rd_ptr[AW-1:0]];
  assign {o_coordinate_X, o_coordinate_Y, o_score, o_cos, o_sin} = head;

  // Next-state logic; start restarts the frame from any state.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (i_start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        COLLECT: if (i_end) state_nxt = DRAIN;
        DRAIN:   if (empty) begin
                   state_nxt = IDLE;
                   done_nxt  = 1'b1;
                 end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and the registered frame-done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_frame_done <= done_nxt;
    end
  end

  // FIFO pointers and per-frame counters; start flushes and clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_drop  <= '0;
    end else if (i_start) begin
      rd_ptr  <= '0;
      wr_ptr  <= wr_en ? (AW+1)'(1) : '0;
      o_count <= wr_en ? 10'd1 : 10'd0;
      o_drop  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + (AW+1)'(1);
        o_count <= o_count + 10'd1;
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop_en && o_drop != 16'hFFFF) o_drop <= o_drop + 16'd1;
    end
  end

  // Entry storage; contents are not reset, the pointers make them invisible.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx] <= {i_coordinate_X, i_coordinate_Y, i_score, i_cos, i_sin};
  end

endmodule

// File: doc/keypoint_buffer.md
KEYPOINT_BUFFER -- requirements
Module: keypoint_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning FIFO entries (power of two, 4..1024).
REQ-002 SHALL have parameter MAX_KP, default 500, meaning maximum keypoints accepted per frame (1..1023).
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk  in  1  single clock; one clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame-start pulse from the FAST detector.
- i_end  in  1  frame-end pulse from the FAST detector.
- i_flag  in  1  keypoint-valid strobe.
- i_coordinate_X  in  10  keypoint X.
- i_coordinate_Y  in  10  keypoint Y.
- i_score  in  8  FAST score.
- i_cos  in  12  signed orientation cosine.
- i_sin  in  12  signed orientation sine.
- i_ready  in  1  consumer ready.
- o_valid  out  1  head entry valid.
- o_coordinate_X  out  10  head entry X.
- o_coordinate_Y  out  10  head entry Y.
- o_score  out  8  head entry score.
- o_cos  out  12  head entry cosine.
- o_sin  out  12  head entry sine.
- o_count  out  10  keypoints accepted this frame.
- o_drop  out  16  keypoints dropped this frame.
- o_busy  out  1  state is not IDLE.
- o_frame_done  out  1  one-cycle pulse when the frame is fully drained.

Function
REQ-004 SHALL implement a 52-bit-wide FIFO of DEPTH entries; the entry is {X, Y, score, cos, sin}.
REQ-005 SHALL implement states IDLE, COLLECT and DRAIN.
- IDLE -> COLLECT on i_start.
- COLLECT -> DRAIN on i_end.
- DRAIN -> IDLE when the FIFO is empty, asserting o_frame_done for that one cycle.
REQ-006 SHALL, on entry to COLLECT from any state, flush the FIFO pointers and clear o_count and o_drop in the same cycle. An i_start during COLLECT or DRAIN restarts the frame and does not pulse o_frame_done.
REQ-007 SHALL write an entry on a rising edge in COLLECT when i_flag=1, the FIFO is not full (registered status) and o_count<MAX_KP. In that case o_count increments by 1.
REQ-008 SHALL, when i_flag=1 in COLLECT and the FIFO is full or o_count==MAX_KP, discard the keypoint and increment o_drop, saturating at 16'hFFFF.
REQ-009 SHALL ignore i_flag in IDLE and DRAIN; such keypoints are neither stored nor counted.
REQ-010 SHALL, when i_flag and i_end coincide in COLLECT, process the keypoint per REQ-007/008 before moving to DRAIN.
REQ-011 SHALL treat i_start and i_flag in the same cycle as flush-then-write: the keypoint becomes entry 0 and o_count=1.
REQ-012 SHALL be first-word-fall-through: an entry written at edge N drives o_valid=1 and the head fields from edge N onward (visible in cycle N+1).
REQ-013 SHALL pop the head on a rising edge where o_valid & i_ready; the output is valid in COLLECT and DRAIN. Head fields SHALL hold stable while o_valid=1 and i_ready=0.
REQ-014 SHALL, on a simultaneous pop and write, use the full flag registered before the edge. A write arriving while the FIFO is full is dropped even if a pop occurs in the same cycle.
REQ-015 SHALL have read and write pointers that wrap modulo DEPTH. Full/empty SHALL be derived from pointers carrying one extra wrap bit.
REQ-016 SHALL hold o_valid=0 in IDLE; head fields are don't-care when o_valid=0 but SHALL drive 0 in IDLE.

Reset
REQ-017 SHALL, on i_rst_n=0, asynchronously:
- enter IDLE;
- clear both pointers;
- drive o_valid, o_busy, o_frame_done, o_count, o_drop and all head fields to 0.
REQ-018 SHALL, on reset mid-frame, discard all buffered entries; FIFO memory contents need not be cleared.

Configuration
REQ-019 SHALL support macro KP_SCORE_FILTER_EN.
- When defined: adds input i_score_th (8 bits). Keypoints with i_score<i_score_th are silently discarded and counted in neither o_count nor o_drop.
- When undefined: the port is absent and every i_flag keypoint is handled per REQ-007/008.

Verification
REQ-020 SHALL cover:
- Basic frame: i_start, 3 flags (X=5,10,15), i_end, i_ready=1 -> 3 entries out in order; o_count=3, o_drop=0; o_frame_done pulses once after the last pop; state IDLE.
- Overflow: DEPTH=4, i_ready=0, 6 flags in COLLECT -> 4 entries stored, o_drop=2; release i_ready -> exactly first 4 keypoints out.
- Cap: MAX_KP=2, 5 flags with i_ready=1 -> o_count=2, o_drop=3.
- Corner cases:
  - i_start and i_flag in the same cycle mid-DRAIN -> old entries flushed, o_count=1, no o_frame_done.
  - i_end coincides with a flag -> that keypoint stored.
  - Reset mid-COLLECT with 3 entries -> o_valid=0 and counters 0 immediately.
- With KP_SCORE_FILTER_EN, i_score_th=8'd20, scores 10,20,30 -> only scores 20 and 30 stored; o_count=2, o_drop=0.
